// File: rtl/mbist_march_seq.sv
// MBIST march-element sequencer: steps through stimulus entries, sweeps the
// address range per element (direction/repeat/reverse) and stops on compare error.
module mbist_march_seq #(
   parameter int unsigned             BIST_ADDR_WD    = 9,
   parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
   parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
   parameter int unsigned             BIST_STI_CNT    = 8,
   parameter int unsigned             BIST_STI_IDX_WD = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bist_start,
   input  logic                       op_read,
   input  logic                       op_write,
   input  logic                       op_updown,
   input  logic                       op_reverse,
   input  logic                       op_repeatflag,
   input  logic                       last_op,
   input  logic                       cmp_error,
   output logic                       op_run,
   output logic                       op_reinit,
   output logic [BIST_STI_IDX_WD-1:0] sti_idx,
   output logic [BIST_ADDR_WD-1:0]    mem_addr,
   output logic                       mem_cs,
   output logic                       mem_we,
   output logic                       bist_busy,
   output logic                       bist_done,
   output logic                       bist_error
);

   typedef enum logic [2:0] {IDLE, INIT, RUN, NEXT, DONE, FAIL} state_t;

   localparam logic [BIST_STI_IDX_WD-1:0] IDX_LAST = BIST_STI_IDX_WD'(BIST_STI_CNT - 1);
   localparam logic [BIST_STI_IDX_WD-1:0] IDX_ONE  = BIST_STI_IDX_WD'(1);
   localparam logic [BIST_ADDR_WD-1:0]    ADDR_ONE = BIST_ADDR_WD'(1);

   state_t                       state, state_nxt;
   logic                         pass, pass_nxt;
   logic [BIST_ADDR_WD-1:0]      addr_nxt;
   logic [BIST_STI_IDX_WD-1:0]   idx_nxt;
   logic                         dir, dir_rep, terminal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pass     <= 1'b0;
         mem_addr <= BIST_ADDR_START;
         sti_idx  <= '0;
      end else begin
         state    <= state_nxt;
         pass     <= pass_nxt;
         mem_addr <= addr_nxt;
         sti_idx  <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pass_nxt   = pass;
      addr_nxt   = mem_addr;
      idx_nxt    = sti_idx;
      op_run     = 1'b0;
      op_reinit  = 1'b0;
      mem_cs     = 1'b0;
      mem_we     = 1'b0;
      bist_busy  = 1'b0;
      bist_done  = 1'b0;
      bist_error = 1'b0;

      // dir_rep is the direction the second pass will take once pass flips to 1
      dir      = op_updown ^ (pass & op_reverse);
      dir_rep  = op_updown ^ op_reverse;
      terminal = dir ? (mem_addr == BIST_ADDR_END) : (mem_addr == BIST_ADDR_START);

      case (state)
         IDLE: begin
            if (bist_start) state_nxt = INIT;
         end
         INIT: begin
            op_reinit = 1'b1;
            bist_busy = 1'b1;
            pass_nxt  = 1'b0;
            addr_nxt  = op_updown ? BIST_ADDR_START : BIST_ADDR_END;
            state_nxt = RUN;
         end
         RUN: begin
            op_run    = 1'b1;
            bist_busy = 1'b1;
            mem_cs    = op_read | op_write;
            mem_we    = op_write;
            if (last_op) begin
               if (!terminal) begin
                  addr_nxt = dir ? (mem_addr + ADDR_ONE) : (mem_addr - ADDR_ONE);
               end else if (op_repeatflag && !pass) begin
                  pass_nxt = 1'b1;
                  addr_nxt = dir_rep ? BIST_ADDR_START : BIST_ADDR_END;
               end else begin
                  state_nxt = NEXT;
               end
            end
         end
         NEXT: begin
            bist_busy = 1'b1;
            if (sti_idx == IDX_LAST) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = sti_idx + IDX_ONE;
               state_nxt = INIT;
            end
         end
         DONE, FAIL: begin
            bist_done  = 1'b1;
            bist_error = (state == FAIL);
            if (bist_start) begin
               idx_nxt   = '0;
               state_nxt = INIT;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A compare error freezes address/index/pass so the failing location stays visible
      if (bist_busy && cmp_error) begin
         state_nxt = FAIL;
         pass_nxt  = pass;
         addr_nxt  = mem_addr;
         idx_nxt   = sti_idx;
      end
   end

endmodule

// File: tb/tb_mbist_march_seq.sv
// Directed bench for mbist_march_seq: models the op selector and stimulus table,
// scoreboards every memory access and checks sequencing, timing and error handling.
module tb_mbist_march_seq;

   typedef struct packed {
      logic [8:0] addr;
      logic       we;
      logic [2:0] idx;
   } acc_t;

   logic       clk, rst, bist_start, cmp_error;
   logic       op_read, op_write, op_updown, op_reverse, op_repeatflag, last_op;
   logic       op_run, op_reinit, mem_cs, mem_we, bist_busy, bist_done, bist_error;
   logic [2:0] sti_idx;
   logic [8:0] mem_addr;

   int   checks = 0;
   int   failures = 0;
   acc_t sb[$];
   logic [8:0] last_addr;

   // stimulus table (3 elements used)
   int   nops [8];
   logic opw  [8][2];
   logic up   [8];
   logic rev  [8];
   logic rpt  [8];
   logic op_idx;

   mbist_march_seq #(
      .BIST_ADDR_WD(9), .BIST_ADDR_START(9'd0), .BIST_ADDR_END(9'd3),
      .BIST_STI_CNT(3), .BIST_STI_IDX_WD(3)
   ) dut (
      .clk(clk), .rst(rst), .bist_start(bist_start),
      .op_read(op_read), .op_write(op_write), .op_updown(op_updown),
      .op_reverse(op_reverse), .op_repeatflag(op_repeatflag), .last_op(last_op),
      .cmp_error(cmp_error), .op_run(op_run), .op_reinit(op_reinit),
      .sti_idx(sti_idx), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
      .bist_busy(bist_busy), .bist_done(bist_done), .bist_error(bist_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // op selector model: rewinds on re_init, advances on run, wraps after the last op
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            op_idx <= 1'b0;
      else if (op_reinit) op_idx <= 1'b0;
      else if (op_run)    op_idx <= last_op ? 1'b0 : op_idx + 1'b1;
   end

   always_comb begin
      op_write      = opw[sti_idx][op_idx];
      op_read       = ~opw[sti_idx][op_idx];
      op_updown     = up[sti_idx];
      op_reverse    = rev[sti_idx];
      op_repeatflag = rpt[sti_idx];
      last_op       = (int'(op_idx) == nops[sti_idx] - 1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_el(input int e, input int n, input logic w0, input logic w1,
                         input logic u, input logic rv, input logic rp);
      nops[e] = n; opw[e][0] = w0; opw[e][1] = w1;
      up[e] = u; rev[e] = rv; rpt[e] = rp;
   endtask

   task automatic build_expected();
      logic       d;
      logic [8:0] a;
      sb.delete();
      for (int e = 0; e < 3; e++)
         for (int p = 0; p <= int'(rpt[e]); p++) begin
            d = up[e] ^ (p[0] & rev[e]);
            for (int i = 0; i < 4; i++) begin
               a = d ? 9'(i) : 9'(3 - i);
               for (int k = 0; k < nops[e]; k++)
                  sb.push_back('{a, opw[e][k], 3'(e)});
               last_addr = a;
            end
         end
   endtask

   function automatic int exp_cycles();
      int t = 1;
      for (int e = 0; e < 3; e++) t += 2 + nops[e] * 4 * (1 + int'(rpt[e]));
      return t;
   endfunction

   task automatic start_pulse();
      @(negedge clk); bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
   endtask

   // Called at the first negedge after start (INIT); returns the cycle bist_done was seen.
   task automatic run_seq(input logic err_en, input logic [2:0] err_el, input logic [8:0] err_addr,
                          input int start_glitch, output int cyc, output int reinits,
                          output int first_cs);
      acc_t e;
      bit   injected = 0;
      cyc = 1; reinits = 0; first_cs = 0;
      while (cyc < 200) begin
         if (op_reinit) reinits++;
         if (mem_cs) begin
            if (first_cs == 0) first_cs = cyc;
            if (sb.size() == 0) check("unexpected_access", 32'(mem_addr), 32'h1ff);
            else begin
               e = sb.pop_front();
               check("access", 32'({mem_addr, mem_we, sti_idx}), 32'(e));
            end
         end
         if (bist_done) break;
         if (err_en && !injected && mem_cs && last_op && sti_idx == err_el && mem_addr == err_addr) begin
            cmp_error = 1'b1;
            injected = 1;
         end
         if (cyc == start_glitch) bist_start = 1'b1;
         @(negedge clk);
         cyc++;
         cmp_error = 1'b0;
         bist_start = 1'b0;
      end
      check("done_within_budget", 32'(bist_done), 32'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outs"}, 32'({op_run, op_reinit, mem_cs, mem_we, bist_busy, bist_done, bist_error}), 32'(0));
      check({tag, "_addr"}, 32'(mem_addr), 32'(0));
      check({tag, "_idx"}, 32'(sti_idx), 32'(0));
   endtask

   initial begin
      int cyc, reinits, first_cs;
      rst = 1'b1; bist_start = 1'b0; cmp_error = 1'b0;
      for (int e = 0; e < 8; e++) set_el(e, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // A: write-up / read-write-down / read-up repeat+reverse
      set_el(0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      set_el(1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      set_el(2, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("idle");

      build_expected();
      start_pulse();
      check("a_init", 32'({op_reinit, bist_busy, bist_done, sti_idx}), 32'({1'b1, 1'b1, 1'b0, 3'd0}));
      run_seq(1'b0, 3'd0, 9'd0, 0, cyc, reinits, first_cs);
      check("a_cycles", 32'(cyc), 32'(exp_cycles()));
      check("a_first_access", 32'(first_cs), 32'(2));
      check("a_reinits", 32'(reinits), 32'(3));
      check("a_done_flags", 32'({bist_done, bist_error, bist_busy, mem_cs}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
      check("a_final_idx", 32'(sti_idx), 32'(2));
      check("a_final_addr", 32'(mem_addr), 32'(last_addr));
      check("a_sb_empty", 32'(sb.size()), 32'(0));
      @(negedge clk);
      check("a_done_hold", 32'({bist_done, mem_addr}), 32'({1'b1, last_addr}));

      // B: restart from DONE, repeat without reverse; start pulse mid-RUN ignored
      set_el(0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      set_el(1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      set_el(2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      build_expected();
      start_pulse();
      check("b_restart", 32'({bist_done, bist_error, op_reinit, sti_idx}), 32'({1'b0, 1'b0, 1'b1, 3'd0}));
      run_seq(1'b0, 3'd0, 9'd0, 5, cyc, reinits, first_cs);
      check("b_cycles", 32'(cyc), 32'(exp_cycles()));
      check("b_reinits", 32'(reinits), 32'(3));
      check("b_final", 32'({bist_error, sti_idx, mem_addr}), 32'({1'b0, 3'd2, last_addr}));
      check("b_sb_empty", 32'(sb.size()), 32'(0));

      // C: cmp_error at address 2 of element 1
      set_el(0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      set_el(1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_el(2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      build_expected();
      start_pulse();
      run_seq(1'b1, 3'd1, 9'd2, 0, cyc, reinits, first_cs);
      check("c_fail_cycle", 32'(cyc), 32'(11));
      check("c_fail_flags", 32'({bist_done, bist_error, bist_busy, mem_cs, op_run}), 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      check("c_frozen", 32'({sti_idx, mem_addr}), 32'({3'd1, 9'd2}));
      check("c_sb_left", 32'(sb.size()), 32'(5));
      sb.delete();
      @(negedge clk); cmp_error = 1'b1;
      @(negedge clk); cmp_error = 1'b0;
      check("c_fail_hold", 32'({bist_done, bist_error, sti_idx, mem_addr}), 32'({1'b1, 1'b1, 3'd1, 9'd2}));

      // D: error coincident with last element's terminal op still ends in FAIL
      build_expected();
      start_pulse();
      check("d_restart", 32'({bist_error, bist_done, sti_idx}), 32'({1'b0, 1'b0, 3'd0}));
      run_seq(1'b1, 3'd2, 9'd3, 0, cyc, reinits, first_cs);
      check("d_fail_cycle", 32'(cyc), 32'(exp_cycles() - 1));
      check("d_fail_flags", 32'({bist_done, bist_error, sti_idx, mem_addr}), 32'({1'b1, 1'b1, 3'd2, 9'd3}));
      check("d_sb_empty", 32'(sb.size()), 32'(0));

      // E: asynchronous reset mid-RUN, then cmp_error in IDLE is ignored
      start_pulse();
      repeat (3) @(negedge clk);
      check("e_running", 32'({op_run, bist_busy}), 32'({1'b1, 1'b1}));
      #2 rst = 1'b1;
      #1 check_reset_outputs("e_async_reset");
      @(negedge clk); rst = 1'b0;
      @(negedge clk); cmp_error = 1'b1;
      @(negedge clk); cmp_error = 1'b0;
      check_reset_outputs("e_idle_err_ignored");

      // recovery run after reset
      build_expected();
      start_pulse();
      run_seq(1'b0, 3'd0, 9'd0, 0, cyc, reinits, first_cs);
      check("e_cycles", 32'(cyc), 32'(exp_cycles()));
      check("e_pass", 32'({bist_error, sti_idx}), 32'({1'b0, 3'd2}));
      check("e_sb_empty", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
